data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Sequencing controller and two-port arbiter in front of the byte-addressed, strobe-triggered data memory.
- Port A is the load/store stage. Port B is the secondary master (debug/DMA loader).
- Converts a level req/ack handshake into clean setup → strobe → capture phases, so the memory's edge-sensitive read/write strobes see stable address and data.
- Applies fixed priority with starvation relief, and rejects misaligned or out-of-range accesses without touching memory.

Parameters:
- N, 32, address and data width of both requester ports and of the memory data bus.
- ADDR_WIDTH, 19, implemented memory address bits; addresses ≥ 2^ADDR_WIDTH are out of range.
- STARVE_LIMIT, 2, consecutive A grants allowed while B is waiting before B is forced.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  port A request; held with its fields stable until a_ack.
- a_we  in  1  1 = write, 0 = read.
- a_byte  in  1  1 = byte access, 0 = 32-bit word access.
- a_addr  in  N  byte address.
- a_wdata  in  N  write data; byte writes use [7:0].
- a_ack  out  1  one-cycle completion pulse.
- a_err  out  1  valid with a_ack; access rejected.
- a_rdata  out  N  read data; valid while a_ack=1.
- b_req, b_we, b_byte, b_addr, b_wdata, b_ack, b_err, b_rdata: same as port A, for port B.
- mem_addr  out  N  memory address.
- mem_wdata  out  N  memory write data.
- mem_isByte  out  1  byte/word select to memory.
- mem_re  out  1  read strobe; one-cycle pulse.
- mem_we  out  1  write strobe; one-cycle pulse.
- mem_rdata  in  N  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; starve counter = 0.
  - All outputs 0: acks, errs, rdata, mem_* outputs, busy.
  - An in-flight access is discarded with no ack. Strobes drop immediately, even mid-STROBE.
- States: IDLE, SETUP, STROBE, RESP, ERR.
- IDLE, arbitration at each rising edge:
  - Only one req high → that port wins.
  - Both high → A wins, unless starve_cnt == STARVE_LIMIT, in which case B wins.
  - Latch the winner's we, byte, addr and wdata into internal registers.
- Starve counter:
  - Increments when A wins while b_req=1, saturating at STARVE_LIMIT.
  - Clears when B wins, or in any IDLE cycle with b_req=0.
- Validity check on the winner, evaluated in IDLE:
  - Error if the word access is misaligned (byte=0 and addr[1:0] ≠ 0).
  - Error if addr[N-1:ADDR_WIDTH] ≠ 0.
  - Error → next state ERR. Otherwise → next state SETUP.
- SETUP (1 cycle): mem_addr, mem_wdata and mem_isByte driven from latched values; mem_re = mem_we = 0.
- STROBE (1 cycle):
  - Exactly one of mem_re or mem_we = 1, selected by latched we.
  - Address, data and isByte held unchanged.
  - On a read, mem_rdata is captured at the closing edge: word reads take all N bits; byte reads give {24'h0, mem_rdata[7:0]}, upper bits zero-extended (memory may drive z there).
- RESP (1 cycle): granted port's ack = 1, err = 0.
  - Read: rdata = captured value.
  - Write: rdata = 0.
  - Next state IDLE.
- ERR (1 cycle): granted port's ack = 1, err = 1, rdata = 0; no strobe issued; next state IDLE.
- Latency:
  - Valid access: request sampled at edge 0 → ack during cycle 3. A port allows 4 cycles per access, back-to-back (the IDLE cycle re-arbitrates).
  - Error: ack during cycle 1.
- Handshake rules:
  - Requester drops req in the cycle after seeing ack. If req is still high in IDLE, it is a new request.
  - The non-granted port's req is ignored until IDLE; its ack/err/rdata stay 0.
  - Only the granted port's ack/err/rdata ever assert.
- mem_addr, mem_wdata and mem_isByte hold their last values in IDLE/RESP/ERR.
- Strobes are registered outputs, never combinational from req.

Test Plan:
- Reset and idle: assert rst mid-STROBE of a write to 0x10 → mem_we falls immediately, no a_ack. After release, all outputs 0, busy = 0, and a read of 0x10 returns the old value.
- Word round-trip: A writes 0xDEADBEEF to 0x100, then reads 0x100 → mem_we pulse for exactly 1 cycle in cycle 2; read a_ack in cycle 3 with a_rdata = 0xDEADBEEF.
- Byte read: B byte-reads 0x101 after the above → b_rdata = 0x000000BE; mem_isByte = 1 during SETUP/STROBE.
- Arbitration and starvation (STARVE_LIMIT = 2): a_req and b_req held continuously → grant order A, A, B, A, A, B; each ack only on its own port.
- Error paths: A word-reads 0x102 → a_ack = a_err = 1 in cycle 1, no mem strobe. B reads 0x00080000 → b_err = 1.
- Simultaneous arrival: A and B both raise req in the same cycle from reset → A is served first, B's ack arrives 4 cycles after A's ack.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Requester-side bundle for one data-memory port: level req/ack handshake plus
// access fields (write, byte, address, data) and the completion response.
interface data_mem_arbiter_if #(
    parameter int N = 32
);
    logic         req;
    logic         we;
    logic         is_byte;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic         ack;
    logic         err;
    logic [N-1:0] rdata;

    modport master (
        output req, we, is_byte, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, is_byte, addr, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and setup/strobe/capture sequencer in front of a strobe-triggered
// byte-addressed data memory; port A has priority with starvation relief for port B.
module data_mem_arbiter #(
    parameter int N            = 32,
    parameter int ADDR_WIDTH   = 19,
    parameter int STARVE_LIMIT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    data_mem_arbiter_if.slave      a,
    data_mem_arbiter_if.slave      b,
    output logic [N-1:0]           mem_addr,
    output logic [N-1:0]           mem_wdata,
    output logic                   mem_isByte,
    output logic                   mem_re,
    output logic                   mem_we,
    input  logic [N-1:0]           mem_rdata,
    output logic                   busy
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RESP,
        S_ERR
    } state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_t;

    state_t        state, next_state;
    port_t         grant;
    logic          lat_we;
    logic [CW-1:0] starve_cnt;
    logic [N-1:0]  rdata_q;

    logic          any_req;
    logic          pick_b;
    logic          win_we;
    logic          win_byte;
    logic [N-1:0]  win_addr;
    logic [N-1:0]  win_wdata;
    logic          win_bad;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        any_req    = a.req | b.req;
        pick_b     = b.req && (!a.req || (starve_cnt == STARVE_MAX));
        win_we     = pick_b ? b.we      : a.we;
        win_byte   = pick_b ? b.is_byte : a.is_byte;
        win_addr   = pick_b ? b.addr    : a.addr;
        win_wdata  = pick_b ? b.wdata   : a.wdata;
        win_bad    = (!win_byte && (win_addr[1:0] != 2'b00)) ||
                     ((win_addr >> ADDR_WIDTH) != '0);
        next_state = state;
        unique case (state)
            S_IDLE:   if (any_req) next_state = win_bad ? S_ERR : S_SETUP;
            S_SETUP:  next_state = S_STROBE;
            S_STROBE: next_state = S_RESP;
            S_RESP:   next_state = S_IDLE;
            S_ERR:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= PORT_A;
            lat_we     <= 1'b0;
            starve_cnt <= '0;
            rdata_q    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_isByte <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            state  <= next_state;
            // Strobes are flops so the memory never sees a glitch from the request side.
            mem_re <= (next_state == S_STROBE) && !lat_we;
            mem_we <= (next_state == S_STROBE) &&  lat_we;

            if (state == S_IDLE) begin
                if (any_req) begin
                    grant  <= pick_b ? PORT_B : PORT_A;
                    lat_we <= win_we;
                    // Rejected accesses leave the memory bus at its previous values.
                    if (!win_bad) begin
                        mem_addr   <= win_addr;
                        mem_wdata  <= win_wdata;
                        mem_isByte <= win_byte;
                    end
                end

                if (any_req && pick_b) begin
                    starve_cnt <= '0;
                end else if (a.req && b.req) begin
                    if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
                end else if (!b.req) begin
                    starve_cnt <= '0;
                end
            end

            if (state == S_STROBE) begin
                if (lat_we)          rdata_q <= '0;
                else if (mem_isByte) rdata_q <= {{(N-8){1'b0}}, mem_rdata[7:0]};
                else                 rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        a.ack   = ((state == S_RESP) || (state == S_ERR)) && (grant == PORT_A);
        a.err   = (state == S_ERR) && (grant == PORT_A);
        a.rdata = ((state == S_RESP) && (grant == PORT_A)) ? rdata_q : '0;
        b.ack   = ((state == S_RESP) || (state == S_ERR)) && (grant == PORT_B);
        b.err   = (state == S_ERR) && (grant == PORT_B);
        b.rdata = ((state == S_RESP) && (grant == PORT_B)) ? rdata_q : '0;
        busy    = (state != S_IDLE);
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a byte-array memory model, expected
// completions queued at drive time and retired by an ack monitor.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_isByte, mem_re, mem_we, busy;

    data_mem_arbiter_if #(.N(32)) a_if ();
    data_mem_arbiter_if #(.N(32)) b_if ();

    data_mem_arbiter #(.N(32), .ADDR_WIDTH(19), .STARVE_LIMIT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a_if),
        .b          (b_if),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_isByte (mem_isByte),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_count = 0;
    int   strobe_count = 0;
    int   a_ack_cyc = 0;
    int   b_ack_cyc = 0;
    bit   prev_re = 1'b0;
    bit   prev_we = 1'b0;

    bit [7:0] mem [0:4095];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: little-endian bytes, write committed at the clock edge closing the strobe;
    // junk in the unread upper bits and outside read strobes.
    always_comb begin
        if (!mem_re)         mem_rdata = 32'hFFFF_FFFF;
        else if (mem_isByte) mem_rdata = {24'hA5A5A5, mem[mem_addr[11:0]]};
        else                 mem_rdata = {mem[mem_addr[11:0] + 12'd3], mem[mem_addr[11:0] + 12'd2],
                                          mem[mem_addr[11:0] + 12'd1], mem[mem_addr[11:0]]};
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            if (mem_isByte) begin
                mem[mem_addr[11:0]] <= mem_wdata[7:0];
            end else begin
                mem[mem_addr[11:0]]          <= mem_wdata[7:0];
                mem[mem_addr[11:0] + 12'd1]  <= mem_wdata[15:8];
                mem[mem_addr[11:0] + 12'd2]  <= mem_wdata[23:16];
                mem[mem_addr[11:0] + 12'd3]  <= mem_wdata[31:24];
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mem_re || mem_we) strobe_count++;
        if ((mem_re && prev_re) || (mem_we && prev_we)) check("strobe_width", 32'd2, 32'd1);
        prev_re = mem_re;
        prev_we = mem_we;
        if (!rst && (a_if.ack || b_if.ack)) begin
            ack_count++;
            if (a_if.ack) a_ack_cyc = cyc;
            if (b_if.ack) b_ack_cyc = cyc;
            check("dual_ack", {31'd0, a_if.ack & b_if.ack}, 32'd0);
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 32'd1);
            end else begin
                e = sb.pop_front();
                check("ack_port", {31'd0, b_if.ack}, {31'd0, e.port});
                check("ack_err", {31'd0, e.port ? b_if.err : a_if.err}, {31'd0, e.err});
                check("ack_rdata", e.port ? b_if.rdata : a_if.rdata, e.rdata);
                check("other_err", {31'd0, e.port ? a_if.err : b_if.err}, 32'd0);
                check("other_rdata", e.port ? a_if.rdata : b_if.rdata, 32'd0);
            end
        end
    end

    task automatic push(input bit port, input bit err, input logic [31:0] rdata);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input bit byt,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            b_if.we = we; b_if.is_byte = byt; b_if.addr = addr; b_if.wdata = wdata; b_if.req = req;
        end else begin
            a_if.we = we; a_if.is_byte = byt; a_if.addr = addr; a_if.wdata = wdata; a_if.req = req;
        end
    endtask

    // Called just after a falling edge in an IDLE cycle; returns in the next IDLE cycle.
    task automatic access(input bit port, input bit we, input bit byt, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit exp_err, input logic [31:0] exp_rdata,
                          input bit solo);
        int n = 0;
        int s0 = strobe_count;
        bit got = 1'b0;
        push(port, exp_err, exp_rdata);
        drive(port, 1'b1, we, byt, addr, wdata);
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (solo && !exp_err && n == 1) begin
                check("setup_nostrobe", {31'd0, mem_re | mem_we}, 32'd0);
                check("setup_isbyte", {31'd0, mem_isByte}, {31'd0, byt});
                check("setup_addr", mem_addr, addr);
            end
            if (solo && !exp_err && n == 2) begin
                check("strobe_kind", {30'd0, mem_we, mem_re}, we ? 32'd2 : 32'd1);
                check("strobe_isbyte", {31'd0, mem_isByte}, {31'd0, byt});
            end
            got = port ? b_if.ack : a_if.ack;
        end
        check("ack_seen", {31'd0, got}, 32'd1);
        if (got && solo) begin
            check("latency", n, exp_err ? 32'd1 : 32'd3);
            check("strobe_count", strobe_count - s0, exp_err ? 32'd0 : 32'd1);
        end
        drive(port, 1'b0, we, byt, addr, wdata);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_a"}, {a_if.ack, a_if.err, 30'd0} | a_if.rdata, 32'd0);
        check({tag, "_b"}, {b_if.ack, b_if.err, 30'd0} | b_if.rdata, 32'd0);
        check({tag, "_maddr"}, mem_addr, 32'd0);
        check({tag, "_mwdata"}, mem_wdata, 32'd0);
        check({tag, "_mctl"}, {28'd0, mem_isByte, mem_re, mem_we, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int a0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h1122_3344, 1'b0, 32'd0, 1'b1);

        // Write interrupted by reset in its strobe cycle.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hCAFE_F00D);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_strobe_we", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_we_drop", {31'd0, mem_we}, 32'd0);
        check("rst_no_ack", {31'd0, a_if.ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hCAFE_F00D);
        @(negedge clk);
        check_idle("in_rst");
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_rst");
        access(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'h1122_3344, 1'b1);

        // Word round-trip and byte read.
        access(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1);
        access(1'b0, 1'b0, 1'b0, 32'h100, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        access(1'b1, 1'b0, 1'b1, 32'h101, 32'd0, 1'b0, 32'h0000_00BE, 1'b1);

        // Rejected accesses and the top in-range byte.
        access(1'b0, 1'b0, 1'b0, 32'h102, 32'd0, 1'b1, 32'd0, 1'b1);
        access(1'b1, 1'b0, 1'b0, 32'h0008_0000, 32'd0, 1'b1, 32'd0, 1'b1);
        access(1'b1, 1'b1, 1'b0, 32'h0008_0000, 32'h1234_5678, 1'b1, 32'd0, 1'b1);
        access(1'b1, 1'b1, 1'b1, 32'h0007_FFFF, 32'hFFFF_FF5A, 1'b0, 32'd0, 1'b1);
        access(1'b0, 1'b0, 1'b1, 32'h0007_FFFF, 32'd0, 1'b0, 32'h0000_005A, 1'b1);
        access(1'b0, 1'b0, 1'b0, 32'h100, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b1);

        // Both requests held: expect A, A, B, A, A, B.
        for (int i = 0; i < 6; i++) begin
            if (i == 2 || i == 5) push(1'b1, 1'b0, 32'h0000_00BE);
            else                  push(1'b0, 1'b0, 32'hDEAD_BEEF);
        end
        a0 = ack_count;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h101, 32'd0);
        n = 0;
        while ((ack_count - a0) < 6 && n < 60) begin
            @(negedge clk);
            n++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h101, 32'd0);
        check("starve_acks", ack_count - a0, 32'd6);
        @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        // Simultaneous arrival straight out of reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fork
            access(1'b0, 1'b0, 1'b0, 32'h100, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
            access(1'b1, 1'b0, 1'b1, 32'h101, 32'd0, 1'b0, 32'h0000_00BE, 1'b0);
        join
        check("simul_gap", b_ack_cyc - a_ack_cyc, 32'd4);
        check("final_sb", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
